// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the write-back arbiter
// Purpose : arbitration mode enum, default-width write-back entry, stats width.
// Ports   : none (package).
package wb_arb_pkg;

   // Default widths, mirroring the core's cpu_parameters values.
   localparam int CPU_XLEN    = 32;
   localparam int CPU_RD_W    = 5;
   localparam int STALL_CNT_W = 16;

   typedef enum logic {ARB_PRIO, ARB_RR} arb_mode_e;

   typedef struct packed {
      logic                exc;
      logic [CPU_RD_W-1:0] rd;
      logic [CPU_XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - single-channel synchronous FIFO of write-back entries
// Purpose : buffers one execution unit's results ahead of the arbiter.
// Ports   : clk, rst (async, active-high), push/din, pop/dout (show-ahead),
//           flush (empties the FIFO), full, empty.
module wb_fifo
   import wb_arb_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = wb_entry_t
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  logic   pop,
   input  logic   flush,
   input  entry_t din,
   output entry_t dout,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - N-channel write-back arbiter with per-channel FIFOs
// Purpose : buffers execute-unit results and issues one register-file write
//           (or exception pulse) per cycle, fixed-priority or round-robin.
// Ports   : clk, rst (async, active-high), mode (0 prio / 1 RR), flush,
//           ch_res/ch_rd/ch_res_v/ch_exc per channel in, ch_ok per channel out,
//           result/rd/result_v write port, exc_v/exc_ch exception pulse.
// Option  : WB_ARB_STATS_EN adds stall_cnt, a 16-bit saturating count per
//           channel of cycles spent valid against a full FIFO.
module wb_arbiter
   import wb_arb_pkg::*;
#(
   parameter  int XLEN  = 32,
   parameter  int N_CH  = 3,
   parameter  int DEPTH = 2,
   parameter  int RD_W  = 5,
   localparam int CH_W  = $clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mode,
   input  logic                   flush,
   input  logic [N_CH*XLEN-1:0]   ch_res,
   input  logic [N_CH*RD_W-1:0]   ch_rd,
   input  logic [N_CH-1:0]        ch_res_v,
   input  logic [N_CH-1:0]        ch_exc,
   output logic [N_CH-1:0]        ch_ok,
   output logic [XLEN-1:0]        result,
   output logic [RD_W-1:0]        rd,
   output logic                   result_v,
   output logic                   exc_v,
   output logic [CH_W-1:0]        exc_ch
`ifdef WB_ARB_STATS_EN
   ,
   output logic [N_CH*STALL_CNT_W-1:0] stall_cnt
`endif
);

   typedef struct packed {
      logic            exc;
      logic [RD_W-1:0] rd;
      logic [XLEN-1:0] data;
   } entry_t;

   entry_t          fifo_din  [N_CH];
   entry_t          fifo_dout [N_CH];
   entry_t          sel;
   logic [N_CH-1:0] full;
   logic [N_CH-1:0] empty;
   logic [N_CH-1:0] push;
   logic [N_CH-1:0] pop;
   logic [CH_W-1:0] ptr;
   logic [CH_W-1:0] grant_idx;
   logic [CH_W-1:0] rr_idx;
   logic            grant_v;
   arb_mode_e       cur_mode;

   assign cur_mode = mode ? ARB_RR : ARB_PRIO;
   assign ch_ok    = ~full;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign fifo_din[i] = '{exc:  ch_exc[i],
                             rd:   ch_rd[i*RD_W +: RD_W],
                             data: ch_res[i*XLEN +: XLEN]};
      // Flush wins over a same-edge push.
      assign push[i] = ch_res_v[i] && !full[i] && !flush;
      assign pop[i]  = grant_v && (grant_idx == CH_W'(i)) && !flush;

      wb_fifo #(
         .DEPTH   (DEPTH),
         .entry_t (entry_t)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[i]),
         .pop   (pop[i]),
         .flush (flush),
         .din   (fifo_din[i]),
         .dout  (fifo_dout[i]),
         .full  (full[i]),
         .empty (empty[i])
      );
   end

   // Both searches run from the lowest-priority candidate to the highest so
   // the last hit is the winner.
   always_comb begin
      grant_v   = 1'b0;
      grant_idx = '0;
      rr_idx    = '0;
      if (cur_mode == ARB_PRIO) begin
         for (int i = N_CH - 1; i >= 0; i--) begin
            if (!empty[i]) begin
               grant_v   = 1'b1;
               grant_idx = CH_W'(i);
            end
         end
      end else begin
         for (int k = N_CH; k >= 1; k--) begin
            rr_idx = CH_W'((int'(ptr) + k) % N_CH);
            if (!empty[rr_idx]) begin
               grant_v   = 1'b1;
               grant_idx = rr_idx;
            end
         end
      end
   end

   assign sel = fifo_dout[grant_idx];

   // The RR pointer only follows round-robin grants; fixed-priority grants
   // leave it alone so switching back resumes where RR left off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result   <= '0;
         rd       <= '0;
         result_v <= 1'b0;
         exc_v    <= 1'b0;
         exc_ch   <= '0;
         ptr      <= CH_W'(N_CH - 1);
      end else begin
         result_v <= 1'b0;
         exc_v    <= 1'b0;
         if (!flush && grant_v) begin
            if (cur_mode == ARB_RR) ptr <= grant_idx;
            if (sel.exc) begin
               exc_v  <= 1'b1;
               exc_ch <= grant_idx;
            end else if (sel.rd != '0) begin
               result_v <= 1'b1;
               result   <= sel.data;
               rd       <= sel.rd;
            end
         end
      end
   end

`ifdef WB_ARB_STATS_EN
   logic [STALL_CNT_W-1:0] stall_q [N_CH];

   for (genvar i = 0; i < N_CH; i++) begin : g_stall
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            stall_q[i] <= '0;
         end else if (ch_res_v[i] && full[i] && (stall_q[i] != '1)) begin
            stall_q[i] <= stall_q[i] + 1'b1;
         end
      end
      assign stall_cnt[i*STALL_CNT_W +: STALL_CNT_W] = stall_q[i];
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;
   localparam int XLEN  = 32;
   localparam int N_CH  = 3;
   localparam int DEPTH = 2;
   localparam int RD_W  = 5;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 mode = 1'b0;
   logic                 flush = 1'b0;
   logic [N_CH*XLEN-1:0] ch_res = '0;
   logic [N_CH*RD_W-1:0] ch_rd = '0;
   logic [N_CH-1:0]      ch_res_v = '0;
   logic [N_CH-1:0]      ch_exc = '0;
   logic [N_CH-1:0]      ch_ok;
   logic [XLEN-1:0]      result;
   logic [RD_W-1:0]      rd;
   logic                 result_v;
   logic                 exc_v;
   logic [1:0]           exc_ch;
`ifdef WB_ARB_STATS_EN
   logic [N_CH*16-1:0]   stall_cnt;
`endif

   wb_arbiter #(.XLEN(XLEN), .N_CH(N_CH), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
      .clk(clk), .rst(rst), .mode(mode), .flush(flush),
      .ch_res(ch_res), .ch_rd(ch_rd), .ch_res_v(ch_res_v), .ch_exc(ch_exc),
      .ch_ok(ch_ok), .result(result), .rd(rd), .result_v(result_v),
      .exc_v(exc_v), .exc_ch(exc_ch)
`ifdef WB_ARB_STATS_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: one queue per channel, plain list semantics.
   typedef struct {
      bit          exc;
      int          rdi;
      logic [31:0] data;
   } ent_t;

   ent_t        mq [N_CH][$];
   int          m_ptr = N_CH - 1;
   bit          m_rv = 0, m_ev = 0;
   int          m_ech = 0, m_rd = 0;
   logic [31:0] m_res = '0;
   int          m_stall [N_CH] = '{0, 0, 0};

   function automatic logic [2:0] m_ok();
      logic [2:0] o;
      for (int i = 0; i < N_CH; i++) o[i] = (mq[i].size() < DEPTH);
      return o;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         mq[i].delete();
         m_stall[i] = 0;
      end
      m_ptr = N_CH - 1; m_rv = 0; m_ev = 0; m_ech = 0; m_rd = 0; m_res = '0;
   endtask

   task automatic model_edge(input bit md, input bit fl, input logic [2:0] v,
                             input logic [2:0] ex, input logic [3*RD_W-1:0] rdv,
                             input logic [3*XLEN-1:0] dv);
      logic [2:0] ok;
      int g;
      ent_t e;
      ok = m_ok();
      g  = -1;
      for (int i = 0; i < N_CH; i++)
         if (v[i] && !ok[i] && m_stall[i] < 65535) m_stall[i]++;
      m_rv = 0;
      m_ev = 0;
      if (fl) begin
         for (int i = 0; i < N_CH; i++) mq[i].delete();
      end else begin
         if (!md) begin
            for (int i = 0; i < N_CH; i++) if (g < 0 && mq[i].size() > 0) g = i;
         end else begin
            for (int k = 1; k <= N_CH; k++)
               if (g < 0 && mq[(m_ptr + k) % N_CH].size() > 0) g = (m_ptr + k) % N_CH;
         end
         if (g >= 0) begin
            e = mq[g].pop_front();
            if (md) m_ptr = g;
            if (e.exc) begin
               m_ev = 1; m_ech = g;
            end else if (e.rdi != 0) begin
               m_rv = 1; m_rd = e.rdi; m_res = e.data;
            end
         end
         for (int i = 0; i < N_CH; i++)
            if (v[i] && ok[i])
               mq[i].push_back('{ex[i], int'(rdv[i*RD_W +: RD_W]), dv[i*XLEN +: XLEN]});
      end
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic step(input bit md, input bit fl, input logic [2:0] v,
                       input logic [2:0] ex, input logic [3*RD_W-1:0] rdv,
                       input logic [3*XLEN-1:0] dv);
      mode = md; flush = fl; ch_res_v = v; ch_exc = ex; ch_rd = rdv; ch_res = dv;
      #1;
      chk("ch_ok", ch_ok, m_ok());
      @(posedge clk);
      model_edge(md, fl, v, ex, rdv, dv);
      #1;
      chk("result_v", result_v, m_rv);
      chk("exc_v", exc_v, m_ev);
      chk("exc_ch", exc_ch, m_ech);
      chk("result", result, m_res);
      chk("rd", rd, m_rd);
   endtask

   typedef struct {
      bit          md, fl;
      logic [2:0]  v, ex;
      logic [4:0]  r0, r1, r2;
      logic [31:0] d0, d1, d2;
      bit          e_rv;
      logic [4:0]  e_rd;
      logic [31:0] e_res;
      bit          e_ev;
      logic [1:0]  e_ech;
      logic [2:0]  e_ok;
   } vec_t;

   vec_t tbl [16];
   int   grants [$];
   int   exp_grants [8] = '{0, 1, 2, 0, 1, 2, 0, 1};

   initial begin
      tbl[0]  = '{0,0,3'b010,3'b000, 0,7,0, 0,32'hDEADBEEF,0, 0,0,0,0,0,3'b111};
      tbl[1]  = '{0,0,3'b000,3'b000, 0,0,0, 0,0,0, 1,7,32'hDEADBEEF,0,0,3'b111};
      tbl[2]  = '{0,0,3'b000,3'b000, 0,0,0, 0,0,0, 0,7,32'hDEADBEEF,0,0,3'b111};
      tbl[3]  = '{0,0,3'b111,3'b000, 1,2,3, 32'h11,32'h22,32'h33, 0,7,32'hDEADBEEF,0,0,3'b111};
      tbl[4]  = '{0,0,3'b000,3'b000, 0,0,0, 0,0,0, 1,1,32'h11,0,0,3'b111};
      tbl[5]  = '{0,0,3'b000,3'b000, 0,0,0, 0,0,0, 1,2,32'h22,0,0,3'b111};
      tbl[6]  = '{0,0,3'b000,3'b000, 0,0,0, 0,0,0, 1,3,32'h33,0,0,3'b111};
      tbl[7]  = '{0,0,3'b000,3'b000, 0,0,0, 0,0,0, 0,3,32'h33,0,0,3'b111};
      tbl[8]  = '{0,0,3'b101,3'b100, 0,0,5, 32'h44,0,32'h55, 0,3,32'h33,0,0,3'b111};
      tbl[9]  = '{0,0,3'b000,3'b000, 0,0,0, 0,0,0, 0,3,32'h33,0,0,3'b111};
      tbl[10] = '{0,0,3'b000,3'b000, 0,0,0, 0,0,0, 0,3,32'h33,1,2,3'b111};
      tbl[11] = '{0,0,3'b000,3'b000, 0,0,0, 0,0,0, 0,3,32'h33,0,2,3'b111};
      tbl[12] = '{0,0,3'b111,3'b000, 1,2,3, 32'h70,32'h71,32'h72, 0,3,32'h33,0,2,3'b111};
      tbl[13] = '{0,0,3'b111,3'b000, 1,2,3, 32'h70,32'h71,32'h72, 1,1,32'h70,0,2,3'b001};
      tbl[14] = '{0,1,3'b001,3'b000, 1,0,0, 32'h70,0,0, 0,1,32'h70,0,2,3'b111};
      tbl[15] = '{0,0,3'b000,3'b000, 0,0,0, 0,0,0, 0,1,32'h70,0,2,3'b111};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_result_v", result_v, 0);
      chk("reset_exc_v", exc_v, 0);
      chk("reset_result", result, 0);
      chk("reset_rd", rd, 0);
      chk("reset_exc_ch", exc_ch, 0);
      rst = 0;
      model_reset();
      #1;
      chk("reset_ch_ok", ch_ok, 3'b111);

      // Directed table
      foreach (tbl[n]) begin
         step(tbl[n].md, tbl[n].fl, tbl[n].v, tbl[n].ex,
              {tbl[n].r2, tbl[n].r1, tbl[n].r0}, {tbl[n].d2, tbl[n].d1, tbl[n].d0});
         chk($sformatf("tbl%0d_result_v", n), result_v, tbl[n].e_rv);
         chk($sformatf("tbl%0d_rd", n), rd, tbl[n].e_rd);
         chk($sformatf("tbl%0d_result", n), result, tbl[n].e_res);
         chk($sformatf("tbl%0d_exc_v", n), exc_v, tbl[n].e_ev);
         chk($sformatf("tbl%0d_exc_ch", n), exc_ch, tbl[n].e_ech);
         chk($sformatf("tbl%0d_ch_ok", n), ch_ok, tbl[n].e_ok);
      end

      // Round-robin with all channels saturated: grants rotate from ch0.
      for (int c = 0; c < 9; c++) begin
         step(1, 0, 3'b111, 3'b000, {5'd3, 5'd2, 5'd1}, {32'h102, 32'h101, 32'h100});
         if (c == 2) chk("rr_ch_ok_e3", ch_ok, 3'b010);
         if (result_v) grants.push_back(int'(rd) - 1);
      end
      chk("rr_grant_count", grants.size(), 8);
      for (int i = 0; i < 8 && i < grants.size(); i++)
         chk($sformatf("rr_grant%0d", i), grants[i], exp_grants[i]);
      repeat (6) step(1, 0, 3'b000, 3'b000, '0, '0);
      chk("rr_drained_ok", ch_ok, 3'b111);

      // Randomised run against the model, with one asynchronous reset.
      for (int c = 0; c < 600; c++) begin
         logic [2:0]  v, ex;
         logic [14:0] rdv;
         logic [95:0] dv;
         bit          md, fl;
         if (c == 300) begin
            rst = 1;
            #2;
            chk("midrst_result_v", result_v, 0);
            chk("midrst_exc_v", exc_v, 0);
            chk("midrst_result", result, 0);
            chk("midrst_rd", rd, 0);
            chk("midrst_exc_ch", exc_ch, 0);
            chk("midrst_ch_ok", ch_ok, 3'b111);
            rst = 0;
            model_reset();
         end
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         md = mode;
         fl = ($urandom_range(0, 24) == 0);
         for (int i = 0; i < N_CH; i++) begin
            v[i]  = ($urandom_range(0, 3) != 0);
            ex[i] = ($urandom_range(0, 5) == 0);
            rdv[i*RD_W +: RD_W] = 5'($urandom_range(0, 3));
            dv[i*XLEN +: XLEN]  = $urandom;
         end
         step(md, fl, v, ex, rdv, dv);
      end
      repeat (8) step(mode, 0, 3'b000, 3'b000, '0, '0);
      chk("final_ch_ok", ch_ok, 3'b111);

`ifdef WB_ARB_STATS_EN
      for (int i = 0; i < N_CH; i++)
         chk($sformatf("stall_cnt%0d", i), stall_cnt[i*16 +: 16], m_stall[i]);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
